equ_38_41_rb: RTL and testbench
===============================

Name: equ_38_41_rb

Overview:
- Demosaicing (CFA) datapath stage implementing equations 38–41.
- Reconstructs a missing red/blue sample at a pixel. Combines the pixel's green value with horizontal and vertical colour-difference estimates, weighted by directional scale factors.
- Sits after the green-interpolation and direction-weight stages; feeds the full-RGB output.
- Fully pipelined: one result per clock.

Parameters:
- PIX_W, 12, pixel width of green and RB.
- DIFF_W, 14, width of green_h/green_v (two's complement).
- WT_W, 8, width of scaled_h/scaled_v (unsigned fraction, 256 = 1.0).
- FRAC_SH, 8, right-shift applied to the weighted sum (equals WT_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- green  in  12  unsigned green value at the pixel.
- scaled_h  in  8  unsigned horizontal weight.
- scaled_v  in  8  unsigned vertical weight.
- green_h  in  14  signed horizontal colour-difference estimate (R−G or B−G).
- green_v  in  14  signed vertical colour-difference estimate.
- RB  out  12  reconstructed red/blue sample, unsigned.

Behaviour:
- One clock domain. Reset is synchronous and active-high: on a rising clk edge with rst=1, all pipeline registers and RB clear to 0.
- Stage 1 (registered at the first edge):
  - rb_dh = signed(green_h) × unsigned(scaled_h).
  - rb_dv = signed(green_v) × unsigned(scaled_v).
  - Each product is held as 22-bit signed. No overflow is possible: 8192×255 < 2^21.
  - green is registered alongside the products.
- Stage 2 (registered at the second edge):
  - sum = rb_dh + rb_dv, 23-bit signed.
  - corr = (sum + 128) >>> 8, arithmetic shift; rounds half toward +inf.
  - val = green + corr, evaluated signed and wide enough to avoid wrap.
  - RB = 0 if val < 0; 4095 if val > 4095; else val[11:0].
- Latency: 2 clocks from input sample edge to RB.
- Throughput: 1 per clock. No handshake; inputs are sampled on every edge.
- scaled_h + scaled_v is not checked. Weights summing above 256 are legal and handled purely by saturation.
- rst asserted mid-stream flushes both stages. RB reads 0 on the edge after rst and stays 0 until 2 edges after rst deasserts.
- Inputs present while rst=1 are discarded.

Optional Feature:
- Macro RB_DEBUG_EN.
- When defined: adds outputs rb_dv_o[21:0] and rb_dh_o[21:0] (signed), the stage-1 product registers.
  - They are valid 1 clock after input and are cleared by rst.
  - They are used for bit-exact comparison against the golden model's intermediate columns.
- When undefined: these ports and any extra logic are absent; RB behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 clocks with random inputs -> RB=0 throughout; RB stays 0 for 2 clocks after rst falls, until the first valid sample emerges.
- Nominal: green=1000, scaled_h=128, scaled_v=128, green_h=200, green_v=100 -> rb_dh=25600, rb_dv=12800, RB=1150 two clocks later.
- Rounding: green=0, green_h=1, scaled_h=128, green_v=0, scaled_v=0 -> RB=1. With scaled_h=127 -> RB=0.
- Negative clip: green=100, green_h=green_v=−1000 (14'h3C18), scaled_h=scaled_v=128 -> corr=−1000, RB=0.
- Positive clip: green=4000, green_h=8191, scaled_h=255, green_v=0, scaled_v=0 -> rb_dh=2088705, RB=4095.
- Pipelining/zero weights: back-to-back vectors each clock, including scaled_h=scaled_v=0 with green=2345 -> outputs appear in order 2 clocks later, matching the file-driven model each cycle; the zero-weight vector yields RB=2345.

Source files
------------

// File: rtl/equ_38_41_rb.sv
// Red/blue reconstruction at a pixel: green plus weighted H/V colour differences,
// rounded, shifted and clipped; two-stage pipeline. Define RB_DEBUG_EN to expose stage-1 products.
module equ_38_41_rb #(
  parameter int PIX_W   = 12,
  parameter int DIFF_W  = 14,
  parameter int WT_W    = 8,
  parameter int FRAC_SH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic        [PIX_W-1:0]        green,
  input  logic        [WT_W-1:0]         scaled_h,
  input  logic        [WT_W-1:0]         scaled_v,
  input  logic        [DIFF_W-1:0]       green_h,
  input  logic        [DIFF_W-1:0]       green_v,
  output logic        [PIX_W-1:0]        RB
`ifdef RB_DEBUG_EN
  ,
  output logic signed [DIFF_W+WT_W-1:0]  rb_dv_o,
  output logic signed [DIFF_W+WT_W-1:0]  rb_dh_o
`endif
);

  localparam int PROD_W = DIFF_W + WT_W;
  localparam int ACC_W  = PROD_W + 2;
  localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1 << (FRAC_SH - 1));
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

  logic signed [PROD_W-1:0] gh_x, gv_x, sh_x, sv_x;
  logic signed [PROD_W-1:0] rb_dh_d, rb_dv_d;
  logic signed [PROD_W-1:0] rb_dh, rb_dv;
  logic        [PIX_W-1:0]  green_q;

  logic signed [PROD_W:0]   sum;
  logic signed [ACC_W-1:0]  rnd, corr, val;
  logic        [PIX_W-1:0]  rb_d;

  // Operands are widened to the product width first; the true product always fits in 22 bits.
  always_comb begin
    gh_x    = PROD_W'($signed(green_h));
    gv_x    = PROD_W'($signed(green_v));
    sh_x    = PROD_W'({1'b0, scaled_h});
    sv_x    = PROD_W'({1'b0, scaled_v});
    rb_dh_d = gh_x * sh_x;
    rb_dv_d = gv_x * sv_x;
  end

  // NOTE: every output of an always_comb is assigned a default before any branch, so no latch is inferred.
  always_comb begin
    sum  = {rb_dh[PROD_W-1], rb_dh} + {rb_dv[PROD_W-1], rb_dv};
    rnd  = {sum[PROD_W], sum} + HALF;
    corr = rnd >>> FRAC_SH;
    val  = {{(ACC_W-PIX_W){1'b0}}, green_q} + corr;
    rb_d = val[PIX_W-1:0];
    if (val < 0)
      rb_d = '0;
    else if (val > PIX_MAX)
      rb_d = '1;
  end

  // NOTE: registers use non-blocking assignments so every stage samples the previous stage's old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_dh   <= '0;
      rb_dv   <= '0;
      green_q <= '0;
      RB      <= '0;
    end else begin
      rb_dh   <= rb_dh_d;
      rb_dv   <= rb_dv_d;
      green_q <= green;
      RB      <= rb_d;
    end
  end

`ifdef RB_DEBUG_EN
  assign rb_dh_o = rb_dh;
  assign rb_dv_o = rb_dv;
`endif

endmodule

// File: tb/tb_equ_38_41_rb.sv
// Self-checking bench for equ_38_41_rb: directed vectors from the test plan plus
// randomized traffic and mid-stream resets, checked against an arithmetic model.
module tb_equ_38_41_rb;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] green;
  logic [7:0]  scaled_h, scaled_v;
  logic [13:0] green_h, green_v;
  logic [11:0] RB;
`ifdef RB_DEBUG_EN
  logic signed [21:0] rb_dv_o, rb_dh_o;
`endif

  int checks   = 0;
  int failures = 0;

  // Model state: expected RB one edge ahead, and a pending directed constant.
  int stage1_exp  = 0;
  int pending_exp = -1;

  always #5 clk = ~clk;

  equ_38_41_rb dut (
    .clk      (clk),
    .rst      (rst),
    .green    (green),
    .scaled_h (scaled_h),
    .scaled_v (scaled_v),
    .green_h  (green_h),
    .green_v  (green_v),
    .RB       (RB)
`ifdef RB_DEBUG_EN
    ,
    .rb_dv_o  (rb_dv_o),
    .rb_dh_o  (rb_dh_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int to_signed14(input logic [13:0] v);
    return int'(v) - (v[13] ? 16384 : 0);
  endfunction

  // Floor division by 256 expressed without shifts.
  function automatic int floor_div256(input int n);
    int q;
    q = n / 256;
    if ((n % 256) != 0 && n < 0) q = q - 1;
    return q;
  endfunction

  function automatic int ref_rb(input int g, input int sh, input int sv,
                                input logic [13:0] gh, input logic [13:0] gv);
    int corr, val;
    corr = floor_div256(to_signed14(gh) * sh + to_signed14(gv) * sv + 128);
    val  = g + corr;
    if (val < 0)    return 0;
    if (val > 4095) return 4095;
    return val;
  endfunction

  // Apply one vector, clock it, then check RB (and debug products) just after the edge.
  task automatic step(input logic r, input int g, input int sh, input int sv,
                      input logic [13:0] gh, input logic [13:0] gv,
                      input int exp_const, input string tag);
    int exp_rb;
    @(negedge clk);
    rst      = r;
    green    = 12'(g);
    scaled_h = 8'(sh);
    scaled_v = 8'(sv);
    green_h  = gh;
    green_v  = gv;
    @(posedge clk);
    #1;
    exp_rb     = r ? 0 : stage1_exp;
    stage1_exp = r ? 0 : ref_rb(g, sh, sv, gh, gv);
    check({tag, "_rb"}, {20'b0, RB}, 32'(exp_rb));
    if (pending_exp >= 0) check({tag, "_const"}, {20'b0, RB}, 32'(pending_exp));
    pending_exp = r ? -1 : exp_const;
`ifdef RB_DEBUG_EN
    check({tag, "_dh"}, 32'(rb_dh_o), 32'(r ? 0 : to_signed14(gh) * sh));
    check({tag, "_dv"}, 32'(rb_dv_o), 32'(r ? 0 : to_signed14(gv) * sv));
`endif
  endtask

  task automatic rand_step(input logic r, input string tag);
    logic [13:0] gh, gv;
    int g, sh, sv;
    g  = int'($urandom_range(0, 4095));
    sh = int'($urandom_range(0, 255));
    sv = int'($urandom_range(0, 255));
    gh = 14'($urandom);
    gv = 14'($urandom);
    case ($urandom_range(0, 7))
      0: begin gh = 14'h1FFF; sh = 255; end
      1: begin gh = 14'h2000; gv = 14'h2000; sh = 255; sv = 255; end
      2: begin sh = 0; sv = 0; end
      default: ;
    endcase
    step(r, g, sh, sv, gh, gv, -1, tag);
  endtask

  initial begin
    rst = 1'b1; green = '0; scaled_h = '0; scaled_v = '0; green_h = '0; green_v = '0;

    // Reset held for two edges with random inputs present.
    rand_step(1'b1, "reset0");
    rand_step(1'b1, "reset1");
    check("reset_rb_zero", {20'b0, RB}, 32'd0);

    // First post-reset edge still shows 0; the vector appears one edge later.
    step(1'b0, 1000, 128, 128, 14'd200, 14'd100, 1150, "post_rst0");
    check("post_rst_zero", {20'b0, RB}, 32'd0);
    step(1'b0, 0, 128, 0, 14'd1, 14'd0, 1, "nominal");
    step(1'b0, 0, 127, 0, 14'd1, 14'd0, 0, "round_up");
    step(1'b0, 100, 128, 128, 14'h3C18, 14'h3C18, 0, "round_down");
    step(1'b0, 4000, 255, 0, 14'd8191, 14'd0, 4095, "neg_clip");
    step(1'b0, 2345, 0, 0, 14'h2ABC, 14'h1234, 2345, "pos_clip");
    step(1'b0, 4095, 255, 255, 14'h1FFF, 14'h1FFF, 4095, "zero_wt");
    step(1'b0, 0, 255, 255, 14'h2000, 14'h2000, 0, "both_max");
    step(1'b0, 0, 0, 0, 14'd0, 14'd0, 0, "both_min");

    // Back-to-back random traffic.
    for (int i = 0; i < 200; i++) rand_step(1'b0, "rand_a");

    // Mid-stream reset flushes both stages.
    rand_step(1'b1, "mid_rst0");
    rand_step(1'b1, "mid_rst1");
    rand_step(1'b0, "mid_rel0");
    for (int i = 0; i < 200; i++) rand_step(1'b0, "rand_b");

    // Drain the pipeline.
    step(1'b0, 0, 0, 0, 14'd0, 14'd0, -1, "drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
